// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display arbiter slice.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } seg7_state_t;

  localparam int SEG7_X_W  = 32;
  localparam int SEG7_EN_W = 8;

  localparam logic [SEG7_X_W-1:0]  SEG7_X_BLANK  = '0;
  localparam logic [SEG7_EN_W-1:0] SEG7_EN_BLANK = '0;

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: searches last_owner+1 .. last_owner+NREQ.
module seg7_rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  assign any = |req;

  // Scan from the far end back toward last_owner+1 so the nearest hit wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NREQ]) begin
        pick                                   = '0;
        pick[(int'(last_owner) + k) % NREQ]    = 1'b1;
        pick_idx = IDX_W'((int'(last_owner) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin owner of the 8-digit display with minimum dwell and a blank gap on handover.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 1048576,
  parameter int HOLD_W      = 21
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [NREQ-1:0]           req,
  input  logic [SEG7_X_W*NREQ-1:0]  req_x,
  input  logic [SEG7_EN_W*NREQ-1:0] req_aen,
  input  logic [SEG7_EN_W*NREQ-1:0] req_dp,
  output logic [NREQ-1:0]           gnt,
  output logic [SEG7_X_W-1:0]       x_out,
  output logic [SEG7_EN_W-1:0]      aen_out,
  output logic [SEG7_EN_W-1:0]      dp_en_out,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  seg7_state_t           state_q, state_d;
  logic [HOLD_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [NREQ-1:0]       gnt_d;
  logic [SEG7_X_W-1:0]   x_d;
  logic [SEG7_EN_W-1:0]  aen_d, dp_d;

  logic [NREQ-1:0]       pick;
  logic [IDX_W-1:0]      pick_idx;
  logic                  any_req;
  logic [NREQ-1:0]       owner_bit;
  logic                  owner_req;
  logic                  others_req;

  seg7_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (any_req)
  );

  // While in OWN, last_q is the current owner.
  assign owner_bit  = NREQ'(1) << last_q;
  assign owner_req  = |(req & owner_bit);
  assign others_req = |(req & ~owner_bit);
  assign busy       = (state_q == OWN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = '0;
    x_d     = SEG7_X_BLANK;
    aen_d   = SEG7_EN_BLANK;
    dp_d    = SEG7_EN_BLANK;
    case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d = OWN;
          gnt_d   = pick;
          cnt_d   = RELOAD;
          last_d  = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - HOLD_W'(1);
        if (!owner_req)
          state_d = others_req ? GAP : IDLE;
        else if (cnt_q == '0 && others_req)
          state_d = GAP;
        // Data is only forwarded when ownership continues, so a handover never mixes sources.
        if (state_d == OWN) begin
          gnt_d = gnt;
          x_d   = req_x[SEG7_X_W*int'(last_q) +: SEG7_X_W];
          aen_d = req_aen[SEG7_EN_W*int'(last_q) +: SEG7_EN_W];
          dp_d  = req_dp[SEG7_EN_W*int'(last_q) +: SEG7_EN_W];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      gnt       <= '0;
      x_out     <= SEG7_X_BLANK;
      aen_out   <= SEG7_EN_BLANK;
      dp_en_out <= SEG7_EN_BLANK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt       <= gnt_d;
      x_out     <= x_d;
      aen_out   <= aen_d;
      dp_en_out <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with NREQ=3, HOLD_CYCLES=4.
module tb_seg7_display_arbiter;

  localparam logic [31:0] X0 = 32'h1111_1111, X1 = 32'h1234_5678;
  localparam logic [31:0] X2 = 32'hCAFE_BABE, X2B = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [2:0]  req;
  logic [95:0] req_x;
  logic [23:0] req_aen, req_dp;
  logic [2:0]  gnt;
  logic [31:0] x_out;
  logic [7:0]  aen_out, dp_en_out;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] x2;
    logic [2:0]  gnt;
    logic [31:0] x;
    logic [7:0]  aen;
    logic [7:0]  dp;
    logic        busy;
  } vec_t;

  vec_t tbl[13];

  seg7_display_arbiter #(
    .NREQ        (3),
    .HOLD_CYCLES (4),
    .HOLD_W      (3)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .req_x     (req_x),
    .req_aen   (req_aen),
    .req_dp    (req_dp),
    .gnt       (gnt),
    .x_out     (x_out),
    .aen_out   (aen_out),
    .dp_en_out (dp_en_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_blank(input string name);
    chk({name, ".gnt"}, {29'd0, gnt}, 32'd0);
    chk({name, ".x"}, x_out, 32'd0);
    chk({name, ".aen"}, {24'd0, aen_out}, 32'd0);
    chk({name, ".dp"}, {24'd0, dp_en_out}, 32'd0);
    chk({name, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    req   = 3'b000;
    clr_n = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n   = 1'b0;
    req     = 3'b111;
    req_x   = {X2, X1, X0};
    req_aen = {8'hF0, 8'hFF, 8'h0F};
    req_dp  = {8'h80, 8'h01, 8'h10};

    tbl[0]  = '{3'b101, X2,  3'b001, 32'h0, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{3'b101, X2,  3'b001, X0,    8'h0F, 8'h10, 1'b1};
    tbl[2]  = '{3'b101, X2,  3'b001, X0,    8'h0F, 8'h10, 1'b1};
    tbl[3]  = '{3'b101, X2,  3'b001, X0,    8'h0F, 8'h10, 1'b1};
    tbl[4]  = '{3'b101, X2,  3'b000, 32'h0, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{3'b101, X2,  3'b100, 32'h0, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{3'b101, X2,  3'b100, X2,    8'hF0, 8'h80, 1'b1};
    tbl[7]  = '{3'b101, X2B, 3'b100, X2B,   8'hF0, 8'h80, 1'b1};
    tbl[8]  = '{3'b101, X2B, 3'b100, X2B,   8'hF0, 8'h80, 1'b1};
    tbl[9]  = '{3'b101, X2B, 3'b000, 32'h0, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{3'b101, X2B, 3'b001, 32'h0, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{3'b000, X2,  3'b000, 32'h0, 8'h00, 8'h00, 1'b0};
    tbl[12] = '{3'b000, X2,  3'b000, 32'h0, 8'h00, 8'h00, 1'b0};

    // Reset held with all requests active, then released idle.
    tick();
    tick();
    chk_blank("rst_hold");
    req = 3'b000;
    clr_n = 1'b1;
    tick();
    tick();
    chk_blank("rst_release");

    // Preemption, live tracking, and drop-to-idle from the table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      req_x[95:64] = tbl[i].x2;
      tick();
      chk($sformatf("vec%0d.gnt", i), {29'd0, gnt}, {29'd0, tbl[i].gnt});
      chk($sformatf("vec%0d.x", i), x_out, tbl[i].x);
      chk($sformatf("vec%0d.aen", i), {24'd0, aen_out}, {24'd0, tbl[i].aen});
      chk($sformatf("vec%0d.dp", i), {24'd0, dp_en_out}, {24'd0, tbl[i].dp});
      chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
    end
    req_x[95:64] = X2;

    // Lone requester keeps the display indefinitely.
    do_reset();
    req = 3'b010;
    tick();
    chk("single.gnt1", {29'd0, gnt}, 32'd2);
    chk("single.x1", x_out, 32'd0);
    for (int i = 2; i < 102; i++) begin
      tick();
      chk($sformatf("single.c%0d", i), {gnt, busy, aen_out, dp_en_out, 5'd0, 8'd0},
          {3'b010, 1'b1, 8'hFF, 8'h01, 5'd0, 8'd0});
      if (x_out !== X1) chk($sformatf("single.x%0d", i), x_out, X1);
    end

    // Early release in the second OWN cycle, then a full reloaded dwell.
    do_reset();
    req = 3'b101;
    tick();
    chk("early.own1", {29'd0, gnt}, 32'd1);
    tick();
    chk("early.own2", {29'd0, gnt}, 32'd1);
    req = 3'b100;
    tick();
    chk_blank("early.gap");
    req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("early.dwell%0d", i), {29'd0, gnt}, 32'd4);
    end
    tick();
    chk("early.gap2", {29'd0, gnt}, 32'd0);

    // Fairness: 4 OWN + 1 GAP per requester, 15-cycle period.
    do_reset();
    req = 3'b111;
    for (int n = 1; n <= 45; n++) begin
      int p;
      logic [2:0] e;
      tick();
      p = (n - 1) % 15;
      e = (p % 5 == 4) ? 3'b000 : (3'b001 << (p / 5));
      chk($sformatf("fair.n%0d", n), {29'd0, gnt}, {29'd0, e});
    end

    // Asynchronous reset mid-OWN, then restart from requester 0's slot.
    do_reset();
    req = 3'b010;
    tick();
    tick();
    chk("midrst.x_before", x_out, X1);
    chk("midrst.gnt_before", {29'd0, gnt}, 32'd2);
    #2;
    clr_n = 1'b0;
    #1;
    chk_blank("midrst.async");
    req = 3'b110;
    tick();
    clr_n = 1'b1;
    tick();
    chk("midrst.regrant", {29'd0, gnt}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
